// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared mul/div types, FUNC_* decode codes and func decode helpers
`ifndef FUNC_MUL
`define FUNC_MUL  4'b0100
`endif
`ifndef FUNC_MULU
`define FUNC_MULU 4'b0101
`endif
`ifndef FUNC_DIV
`define FUNC_DIV  4'b0110
`endif
`ifndef FUNC_DIVU
`define FUNC_DIVU 4'b0111
`endif
`ifndef FUNC_REM
`define FUNC_REM  4'b1000
`endif
`ifndef FUNC_REMU
`define FUNC_REMU 4'b1001
`endif

package muldiv_pkg;

  typedef enum logic [1:0] {MD_IDLE, MD_CALC, MD_FIXUP, MD_DONE} MulDivState;
  typedef enum logic [1:0] {MD_MUL, MD_DIV, MD_REM} MulDivKind;

  // bit0 only selects signedness, so decode on the remaining bits
  function automatic logic is_muldiv_func(input logic [3:0] func);
    logic [3:0] base;
    base = func & 4'b1110;
    return (base == `FUNC_MUL) || (base == `FUNC_DIV) || (base == `FUNC_REM);
  endfunction

  function automatic MulDivKind muldiv_kind(input logic [3:0] func);
    logic [3:0] base;
    base = func & 4'b1110;
    if (base == `FUNC_DIV) return MD_DIV;
    if (base == `FUNC_REM) return MD_REM;
    return MD_MUL;
  endfunction

endpackage

// File: rtl/muldiv_fixup.sv
// rtl/muldiv_fixup.sv - combinational sign correction and divide-by-zero/overflow result select
module muldiv_fixup
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  MulDivKind         kind,
  input  logic              is_unsigned,
  input  logic [XLEN-1:0]   op_a,
  input  logic [XLEN-1:0]   op_b,
  input  logic [XLEN-1:0]   lo,
  input  logic [XLEN-1:0]   hi,
  output logic [XLEN-1:0]   result
);

  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  logic sign_a;
  logic sign_b;
  logic div_zero;
  logic overflow;

  // lo holds product/quotient magnitude, hi holds remainder magnitude
  always_comb begin
    sign_a   = !is_unsigned && op_a[XLEN-1];
    sign_b   = !is_unsigned && op_b[XLEN-1];
    div_zero = (op_b == '0);
    overflow = !is_unsigned && (op_a == MIN_VAL) && (op_b == '1);
    result   = '0;
    case (kind)
      MD_MUL: result = (sign_a ^ sign_b) ? -lo : lo;
      MD_DIV: begin
        if (div_zero)            result = '1;
        else if (overflow)       result = MIN_VAL;
        else if (sign_a ^ sign_b) result = -lo;
        else                     result = lo;
      end
      MD_REM: begin
        if (div_zero)      result = op_a;
        else if (overflow) result = '0;
        else if (sign_a)   result = -hi;
        else               result = hi;
      end
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative mul/div/rem execution controller; MULDIV_EARLY_OUT_EN skips CALC on zero operands
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [3:0]        req_func,
  input  logic [3:0]        req_rd,
  input  logic [XLEN-1:0]   req_a,
  input  logic [XLEN-1:0]   req_b,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [XLEN-1:0]   resp_data,
  output logic [3:0]        resp_rd,
  output logic              resp_illegal,
  output logic              busy,
  output logic [3:0]        busy_rd
);

  localparam int CW = $clog2(XLEN);

`ifdef MULDIV_EARLY_OUT_EN
  localparam bit EARLY_OUT = 1'b1;
`else
  localparam bit EARLY_OUT = 1'b0;
`endif

  MulDivState state, state_nx;

  MulDivKind           kind_q;
  logic                uns_q;
  logic [XLEN-1:0]     a_q;
  logic [XLEN-1:0]     b_q;
  logic [XLEN-1:0]     op_q;
  logic [2*XLEN-1:0]   acc;
  logic [CW-1:0]       counter;
  logic [3:0]          rd_q;
  logic                illegal_q;
  logic [XLEN-1:0]     data_q;
  logic [XLEN-1:0]     fix_result;

  logic                req_legal;
  MulDivKind           req_kind;
  logic                req_uns;
  logic [XLEN-1:0]     mag_a;
  logic [XLEN-1:0]     mag_b;
  logic                zero_op;
  logic                early_skip;
  logic                accept;
  logic [XLEN:0]       mul_sum;
  logic [XLEN:0]       div_shift;
  logic [XLEN:0]       div_diff;

  always_comb begin
    req_legal  = is_muldiv_func(req_func);
    req_kind   = muldiv_kind(req_func);
    req_uns    = req_func[0];
    mag_a      = (!req_uns && req_a[XLEN-1]) ? -req_a : req_a;
    mag_b      = (!req_uns && req_b[XLEN-1]) ? -req_b : req_b;
    zero_op    = (req_kind == MD_MUL) ? ((req_a == '0) || (req_b == '0)) : (req_b == '0);
    early_skip = EARLY_OUT && zero_op;
    accept     = (state == MD_IDLE) && req_valid && !flush;
  end

  // mul: acc = {partial product, multiplier shifting out}; div: acc = {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, op_q} : {(XLEN+1){1'b0}});
    div_shift = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    div_diff  = div_shift - {1'b0, op_q};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= MD_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = MD_IDLE;
    end else begin
      case (state)
        MD_IDLE: begin
          if (req_valid) begin
            if (!req_legal)      state_nx = MD_DONE;
            else if (early_skip) state_nx = MD_FIXUP;
            else                 state_nx = MD_CALC;
          end
        end
        MD_CALC:  if (counter == '0) state_nx = MD_FIXUP;
        MD_FIXUP: state_nx = MD_DONE;
        MD_DONE:  if (resp_ready) state_nx = MD_IDLE;
        default:  state_nx = MD_IDLE;
      endcase
    end
  end

  always_comb begin
    req_ready  = (state == MD_IDLE);
    resp_valid = (state == MD_DONE);
    busy       = (state != MD_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      kind_q    <= MD_MUL;
      uns_q     <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      acc       <= '0;
      counter   <= '0;
      rd_q      <= '0;
      illegal_q <= 1'b0;
      data_q    <= '0;
    end else if (accept) begin
      kind_q    <= req_kind;
      uns_q     <= req_uns;
      a_q       <= req_a;
      b_q       <= req_b;
      rd_q      <= req_rd;
      counter   <= CW'(XLEN-1);
      illegal_q <= !req_legal;
      if (!req_legal) data_q <= '0;
      if (req_kind == MD_MUL) begin
        op_q <= mag_a;
        acc  <= early_skip ? '0 : {{XLEN{1'b0}}, mag_b};
      end else begin
        op_q <= mag_b;
        acc  <= {{XLEN{1'b0}}, mag_a};
      end
    end else if (state == MD_CALC) begin
      if (counter != '0) counter <= counter - CW'(1);
      if (kind_q == MD_MUL)
        acc <= {mul_sum, acc[XLEN-1:1]};
      else if (!div_diff[XLEN])
        acc <= {div_diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else
        acc <= {div_shift[XLEN-1:0], acc[XLEN-2:0], 1'b0};
    end else if (state == MD_FIXUP) begin
      data_q <= fix_result;
    end
  end

  muldiv_fixup #(.XLEN(XLEN)) u_fixup (
    .kind        (kind_q),
    .is_unsigned (uns_q),
    .op_a        (a_q),
    .op_b        (b_q),
    .lo          (acc[XLEN-1:0]),
    .hi          (acc[2*XLEN-1:XLEN]),
    .result      (fix_result)
  );

  assign resp_data    = data_q;
  assign resp_rd      = rd_q;
  assign resp_illegal = illegal_q;
  assign busy_rd      = rd_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer against an arithmetic reference model
module tb_muldiv_sequencer;

  localparam int XLEN = 32;
  localparam logic [31:0] MIN_VAL = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        req_valid;
  logic        req_ready;
  logic [3:0]  req_func;
  logic [3:0]  req_rd;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_data;
  logic [3:0]  resp_rd;
  logic        resp_illegal;
  logic        busy;
  logic [3:0]  busy_rd;

  int checks = 0;
  int errors = 0;

  muldiv_sequencer #(.XLEN(XLEN)) dut (
    .clk          (clk),
    .rst          (rst),
    .flush        (flush),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_func     (req_func),
    .req_rd       (req_rd),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_data    (resp_data),
    .resp_rd      (resp_rd),
    .resp_illegal (resp_illegal),
    .busy         (busy),
    .busy_rd      (busy_rd)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ISA arithmetic rules written directly with SV operators
  function automatic logic [31:0] model(input logic [3:0] f, input logic [31:0] a,
                                        input logic [31:0] b, output logic ill);
    logic       uns;
    logic [3:0] base;
    uns  = f[0];
    base = f & 4'b1110;
    ill  = 1'b0;
    case (base)
      4'b0100: return a * b;
      4'b0110: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (uns) return a / b;
        if (a == MIN_VAL && b == 32'hFFFF_FFFF) return MIN_VAL;
        return $signed(a) / $signed(b);
      end
      4'b1000: begin
        if (b == 0) return a;
        if (uns) return a % b;
        if (a == MIN_VAL && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: begin
        ill = 1'b1;
        return 32'd0;
      end
    endcase
  endfunction

  // Called at a negedge with the DUT idle; returns at a negedge after the response retires
  task automatic run_op(input string tag, input logic [3:0] f, input logic [3:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input int hold);
    logic [31:0] exp;
    logic        ill;
    int          lat_exp;
    int          cyc;
    exp     = model(f, a, b, ill);
    lat_exp = ill ? 0 : XLEN + 1;
`ifdef MULDIV_EARLY_OUT_EN
    if (!ill && (((f & 4'b1110) == 4'b0100) ? (a == 0 || b == 0) : (b == 0))) lat_exp = 1;
`endif
    check({tag, " req_ready"}, req_ready, 1);
    req_valid = 1'b1; req_func = f; req_rd = rd; req_a = a; req_b = b;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 0;
    while (!resp_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check({tag, " latency"}, cyc, lat_exp);
    check({tag, " data"}, resp_data, exp);
    check({tag, " rd"}, resp_rd, rd);
    check({tag, " illegal"}, resp_illegal, ill);
    check({tag, " busy_rd"}, busy_rd, rd);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, " hold data"}, resp_data, exp);
      check({tag, " hold rd"}, resp_rd, rd);
      check({tag, " hold valid"}, resp_valid, 1);
      check({tag, " hold req_ready"}, req_ready, 0);
      check({tag, " hold busy"}, busy, 1);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check({tag, " retire valid"}, resp_valid, 0);
    check({tag, " retire busy"}, busy, 0);
  endtask

  initial begin
    int seen;
    logic [3:0]  funcs [7];
    logic [31:0] ra, rb;
    funcs = '{4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1000, 4'b1001, 4'b0000};
    rst = 1'b1; flush = 1'b0; req_valid = 1'b0; resp_ready = 1'b0;
    req_func = '0; req_rd = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    check("reset resp_valid", resp_valid, 0);
    check("reset busy", busy, 0);
    check("reset busy_rd", busy_rd, 0);
    check("reset resp_data", resp_data, 0);
    check("reset resp_rd", resp_rd, 0);
    check("reset resp_illegal", resp_illegal, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset req_ready", req_ready, 1);

    run_op("mul_7_m6", 4'b0100, 4'd5, 32'd7, 32'hFFFF_FFFA, 0);
    check("mul_7_m6 const", resp_data, 32'hFFFF_FFD6);
    run_op("div_m7_2", 4'b0110, 4'd3, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("rem_m7_2", 4'b1000, 4'd4, 32'hFFFF_FFF9, 32'd2, 0);
    run_op("divu_100_7", 4'b0111, 4'd6, 32'd100, 32'd7, 0);
    run_op("divu_by0", 4'b0111, 4'd7, 32'd100, 32'd0, 0);
    run_op("remu_by0", 4'b1001, 4'd8, 32'd100, 32'd0, 0);
    run_op("div_by0_neg", 4'b0110, 4'd9, 32'hFFFF_FF00, 32'd0, 0);
    run_op("rem_by0_neg", 4'b1000, 4'd9, 32'hFFFF_FF00, 32'd0, 0);
    run_op("div_ovf", 4'b0110, 4'd10, MIN_VAL, 32'hFFFF_FFFF, 0);
    run_op("rem_ovf", 4'b1000, 4'd11, MIN_VAL, 32'hFFFF_FFFF, 0);
    run_op("mul_hold", 4'b0100, 4'd12, 32'd123, 32'hFFFF_FFD3, 5);
    run_op("illegal_add", 4'b0000, 4'd13, 32'd5, 32'd6, 0);
    run_op("mul_zero", 4'b0100, 4'd14, 32'd0, 32'd9, 0);

    // Flush mid-CALC
    req_valid = 1'b1; req_func = 4'b0100; req_rd = 4'd2; req_a = 32'd1000; req_b = 32'd77;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (9) @(negedge clk);
    check("flush busy before", busy, 1);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush req_ready", req_ready, 1);
    check("flush busy", busy, 0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (resp_valid) seen++;
      @(negedge clk);
    end
    check("flush no resp", seen, 0);
    run_op("mul_3_5", 4'b0100, 4'd1, 32'd3, 32'd5, 0);

    // Asynchronous reset mid-operation
    req_valid = 1'b1; req_func = 4'b0110; req_rd = 4'd15; req_a = 32'd999; req_b = 32'd3;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst busy", busy, 0);
    check("midrst resp_valid", resp_valid, 0);
    check("midrst busy_rd", busy_rd, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    run_op("post_rst_remu", 4'b1001, 4'd3, 32'd1001, 32'd10, 0);

    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 5))
        0: ra = 32'd0;
        1: ra = 32'hFFFF_FFFF;
        2: ra = MIN_VAL;
        3: ra = $urandom_range(0, 50);
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = MIN_VAL;
        3: rb = $urandom_range(1, 50);
        default: rb = $urandom;
      endcase
      run_op($sformatf("rand%0d", n), funcs[$urandom_range(0, 6)], 4'($urandom_range(0, 15)),
             ra, rb, $urandom_range(0, 2));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
